// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounces MODE/UP, runs the RUN/SET_HOUR/SET_MIN editor, holds a shadow HH:MM and commits it.
// Latency: raw button edge -> press event after 2 sync + DB_CYCLES cycles; FSM/shadow update on the next edge; load registered.
// Backpressure: none; counter and scanner consume run_en/load/load_*/blink_mask every cycle.
//
// Ports:
//   clk0, rst_n                     clock, asynchronous active-low reset
//   btn_mode, btn_up                raw asynchronous push-buttons, active-high
//   cur_hour_t/u, cur_min_t/u       live BCD time from the counter, copied on entry to edit
//   run_en                          1 = counter advances, 0 = frozen while editing
//   load                            one-cycle commit pulse on the first RUN cycle after SET_MIN
//   load_hour_t/u, load_min_t/u     shadow BCD time (commit value, display source while editing)
//   blink_mask                      {hour_t,hour_u,min_t,min_u}, 1 = blank the digit
module time_set_ctrl #(
  parameter int DB_CYCLES    = 1000,
  parameter int REPEAT_DELAY = 25000,
  parameter int REPEAT_RATE  = 5000,
  parameter int BLINK_HALF   = 12500,
  parameter int TIMEOUT      = 500000
) (
  input  logic       clk0,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic [1:0] cur_hour_t,
  input  logic [3:0] cur_hour_u,
  input  logic [2:0] cur_min_t,
  input  logic [3:0] cur_min_u,
  output logic       run_en,
  output logic       load,
  output logic [1:0] load_hour_t,
  output logic [3:0] load_hour_u,
  output logic [2:0] load_min_t,
  output logic [3:0] load_min_u,
  output logic [3:0] blink_mask
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DW   = $clog2(DB_CYCLES + 1);
  localparam int RW   = $clog2(RMAX + 1);
  localparam int BW   = $clog2(BLINK_HALF + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] REP_DLY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RATE = RW'(REPEAT_RATE);
  localparam logic [BW-1:0] BH_LAST  = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  state_t state, next_state;

  // Index 0 = MODE, index 1 = UP throughout the input path.
  logic [1:0]    sync1, sync2;
  logic [1:0]    db_lvl, db_prev;
  logic [DW-1:0] db_cnt [2];

  logic          mode_press, up_press;
  logic          in_set, rep_evt, up_evt, any_evt, timeout, enter_set;

  logic          rep_act, rep_armed;
  logic [RW-1:0] rep_cnt;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  logic          load_q;

  logic [1:0]    sh_hour_t;
  logic [3:0]    sh_hour_u;
  logic [2:0]    sh_min_t;
  logic [3:0]    sh_min_u;
  logic          cur_hour_ok, cur_min_ok;

  // ---------------- input synchronisers and debouncers ----------------
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_up, btn_mode};
      sync2 <= sync1;
    end
  end

  // The counter only advances while the synchronised level disagrees with
  // the debounced one; any agreeing cycle restarts the stability window.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      db_lvl  <= '0;
      db_prev <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      db_prev <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db_lvl[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign mode_press = db_lvl[0] & ~db_prev[0];
  assign up_press   = db_lvl[1] & ~db_prev[1];
  assign in_set     = (state != ST_RUN);

  // ---------------- auto-repeat ----------------
  // rep_cnt holds the number of cycles since the press (or since the last
  // repeat), so a repeat fires exactly REPEAT_DELAY / REPEAT_RATE later.
  assign rep_evt = in_set & rep_act & db_lvl[1] &
                   (rep_armed ? (rep_cnt == REP_RATE) : (rep_cnt == REP_DLY));

  // MODE wins over UP when both events land in the same cycle.
  assign up_evt  = in_set & ~mode_press & (up_press | rep_evt);
  assign any_evt = mode_press | up_press | rep_evt;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      rep_act   <= 1'b0;
      rep_armed <= 1'b0;
      rep_cnt   <= '0;
    end else if (!in_set || mode_press || !db_lvl[1]) begin
      rep_act   <= 1'b0;
      rep_armed <= 1'b0;
      rep_cnt   <= '0;
    end else if (up_press) begin
      rep_act   <= 1'b1;
      rep_armed <= 1'b0;
      rep_cnt   <= RW'(1);
    end else if (rep_evt) begin
      rep_armed <= 1'b1;
      rep_cnt   <= RW'(1);
    end else if (rep_act) begin
      rep_cnt   <= rep_cnt + 1'b1;
    end
  end

  // ---------------- inactivity timeout ----------------
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (!in_set || any_evt) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout = in_set & ~any_evt & (to_cnt == TO_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RUN:      if (mode_press) next_state = ST_SET_HOUR;
      ST_SET_HOUR: if (mode_press) next_state = ST_SET_MIN;
                   else if (timeout) next_state = ST_RUN;
      ST_SET_MIN:  if (mode_press || timeout) next_state = ST_RUN;
      default:     next_state = ST_RUN;
    endcase
  end

  always_comb begin
    run_en     = (state == ST_RUN);
    load       = load_q;
    blink_mask = 4'b0000;
    if (blink_off) begin
      case (state)
        ST_SET_HOUR: blink_mask = 4'b1100;
        ST_SET_MIN:  blink_mask = 4'b0011;
        default:     blink_mask = 4'b0000;
      endcase
    end
  end

  // Only a MODE commit from SET_MIN pulses load; a timeout leaves it low.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) load_q <= 1'b0;
    else        load_q <= (state == ST_SET_MIN) && mode_press;
  end

  // ---------------- blink phase ----------------
  assign enter_set = (next_state != ST_RUN) && (next_state != state);

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (enter_set || up_evt || !in_set) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (blink_cnt == BH_LAST) begin
      blink_cnt <= '0;
      blink_off <= ~blink_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // ---------------- shadow time ----------------
  // An illegal field arriving from the counter is replaced by 00 so the
  // shadow never carries a code the counter could not hold.
  assign cur_hour_ok = ((cur_hour_t < 2'd2) && (cur_hour_u <= 4'd9)) ||
                       ((cur_hour_t == 2'd2) && (cur_hour_u <= 4'd3));
  assign cur_min_ok  = (cur_min_t <= 3'd5) && (cur_min_u <= 4'd9);

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      sh_hour_t <= '0;
      sh_hour_u <= '0;
      sh_min_t  <= '0;
      sh_min_u  <= '0;
    end else if ((state == ST_RUN) && mode_press) begin
      sh_hour_t <= cur_hour_ok ? cur_hour_t : 2'd0;
      sh_hour_u <= cur_hour_ok ? cur_hour_u : 4'd0;
      sh_min_t  <= cur_min_ok  ? cur_min_t  : 3'd0;
      sh_min_u  <= cur_min_ok  ? cur_min_u  : 4'd0;
    end else if (up_evt && (state == ST_SET_HOUR)) begin
      if ((sh_hour_t == 2'd2) && (sh_hour_u == 4'd3)) begin
        sh_hour_t <= 2'd0;
        sh_hour_u <= 4'd0;
      end else if (sh_hour_u == 4'd9) begin
        sh_hour_t <= sh_hour_t + 2'd1;
        sh_hour_u <= 4'd0;
      end else begin
        sh_hour_u <= sh_hour_u + 4'd1;
      end
    end else if (up_evt && (state == ST_SET_MIN)) begin
      if (sh_min_u == 4'd9) begin
        sh_min_u <= 4'd0;
        sh_min_t <= (sh_min_t == 3'd5) ? 3'd0 : sh_min_t + 3'd1;
      end else begin
        sh_min_u <= sh_min_u + 4'd1;
      end
    end
  end

  assign load_hour_t = sh_hour_t;
  assign load_hour_u = sh_hour_u;
  assign load_min_t  = sh_min_t;
  assign load_min_u  = sh_min_u;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: randomized and directed checks of time_set_ctrl against a time-arithmetic model.
// Latency: stimulus is driven 1 time unit after posedge; outputs are sampled at the same point.
// Backpressure: none.
module tb_time_set_ctrl;

  localparam int DB = 4;
  localparam int RD = 40;
  localparam int RR = 10;
  localparam int BH = 8;
  localparam int TO = 200;
  // Ticks from raw button assertion to the cycle carrying the press event:
  // two synchroniser flops plus DB stable cycles.
  localparam int EVT_LAT = DB + 2;

  logic       clk0 = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic [1:0] cur_hour_t = '0;
  logic [3:0] cur_hour_u = '0;
  logic [2:0] cur_min_t = '0;
  logic [3:0] cur_min_u = '0;
  logic       run_en, load;
  logic [1:0] load_hour_t;
  logic [3:0] load_hour_u;
  logic [2:0] load_min_t;
  logic [3:0] load_min_u;
  logic [3:0] blink_mask;

  time_set_ctrl #(
    .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .BLINK_HALF(BH), .TIMEOUT(TO)
  ) dut (
    .clk0(clk0), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up),
    .cur_hour_t(cur_hour_t), .cur_hour_u(cur_hour_u),
    .cur_min_t(cur_min_t), .cur_min_u(cur_min_u),
    .run_en(run_en), .load(load),
    .load_hour_t(load_hour_t), .load_hour_u(load_hour_u),
    .load_min_t(load_min_t), .load_min_u(load_min_u),
    .blink_mask(blink_mask)
  );

  always #5 clk0 = ~clk0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // ---------------- observation monitor ----------------
  int   load_cnt    = 0;
  int   set_entries = 0;
  int   last_load_v = -1;
  int   last_load_run = -1;
  logic run_prev    = 1'b1;

  always @(negedge clk0) begin
    if (run_prev && !run_en) set_entries++;
    run_prev = run_en;
    if (load) begin
      load_cnt++;
      last_load_v   = (load_hour_t * 10 + load_hour_u) * 100 + load_min_t * 10 + load_min_u;
      last_load_run = run_en;
    end
  end

  function automatic int sh_h();
    return load_hour_t * 10 + load_hour_u;
  endfunction

  function automatic int sh_m();
    return load_min_t * 10 + load_min_u;
  endfunction

  // ---------------- reference model ----------------
  // m_state: 0 = running, 1 = editing hours, 2 = editing minutes.
  int m_state = 0;
  int m_h = 0, m_m = 0, cur_h = 0, cur_m = 0;
  int m_loads = 0, m_load_v = 0;

  // Number of increments produced by holding UP for 'hold' debounced cycles:
  // the press itself, one at RD cycles, then one every RR cycles.
  function automatic int up_events(input int hold);
    if (hold <= RD) return 1;
    return 2 + (hold - 1 - RD) / RR;
  endfunction

  task automatic model_mode();
    case (m_state)
      0: begin m_state = 1; m_h = cur_h; m_m = cur_m; end
      1: m_state = 2;
      default: begin m_state = 0; m_loads++; m_load_v = m_h * 100 + m_m; end
    endcase
  endtask

  task automatic model_up(input int hold);
    int n = up_events(hold);
    if (m_state == 1) m_h = (m_h + n) % 24;
    else if (m_state == 2) m_m = (m_m + n) % 60;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".run_en"}, run_en, (m_state == 0) ? 1 : 0);
    chk({tag, ".hour"}, sh_h(), m_h);
    chk({tag, ".min"}, sh_m(), m_m);
    chk({tag, ".loads"}, load_cnt, m_loads);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk0);
      #1;
    end
  endtask

  task automatic set_cur(input int h, input int m);
    cur_h = h;
    cur_m = m;
    cur_hour_t = 2'(h / 10);
    cur_hour_u = 4'(h % 10);
    cur_min_t  = 3'(m / 10);
    cur_min_u  = 4'(m % 10);
  endtask

  task automatic drive(input bit on_mode, input logic v);
    if (on_mode) btn_mode = v;
    else btn_up = v;
  endtask

  // Contact bounce: every level lasts under DB cycles, so none may register.
  task automatic noise(input bit on_mode);
    int segs = $urandom_range(1, 4);
    for (int s = 0; s < segs; s++) begin
      drive(on_mode, 1'b1);
      tick($urandom_range(1, DB - 1));
      drive(on_mode, 1'b0);
      tick($urandom_range(1, DB - 1));
    end
  endtask

  task automatic push(input bit on_mode, input int hold, input bit noisy);
    if (noisy) noise(on_mode);
    drive(on_mode, 1'b1);
    tick(hold);
    drive(on_mode, 1'b0);
    tick(DB + 4 + $urandom_range(0, 4));
    if (on_mode) model_mode();
    else model_up(hold);
  endtask

  initial begin
    // ---- reset state ----
    tick(3);
    chk("rst.run_en", run_en, 1);
    chk("rst.load", load, 0);
    chk("rst.blink", blink_mask, 0);
    chk("rst.shadow", sh_h() * 100 + sh_m(), 0);
    rst_n = 1'b1;
    tick(2);

    // ---- bounce on MODE: exactly one entry into SET_HOUR ----
    set_cur(13, 47);
    for (int i = 0; i < 15; i++) begin
      btn_mode = ~btn_mode;
      tick(2);
    end
    tick(20);
    btn_mode = 1'b0;
    tick(DB + 4);
    model_mode();
    chk("bounce.entries", set_entries, 1);
    check_model("bounce");
    push(1, 8, 0);
    push(1, 8, 0);
    check_model("bounce.commit");
    chk("bounce.load_val", last_load_v, m_load_v);

    // ---- hour wrap and exact load pulse ----
    set_cur(22, 15);
    push(1, 8, 0);
    check_model("wrap.enter");
    push(0, 8, 0);
    push(0, 8, 0);
    check_model("wrap.hour");
    push(1, 8, 0);
    check_model("wrap.min");
    drive(1, 1'b1);
    tick(EVT_LAT);
    chk("wrap.pre_load", load, 0);
    chk("wrap.pre_run", run_en, 0);
    tick(1);
    chk("wrap.load", load, 1);
    chk("wrap.load_run", run_en, 1);
    chk("wrap.load_val", sh_h() * 100 + sh_m(), 15);
    tick(1);
    chk("wrap.load_end", load, 0);
    drive(1, 1'b0);
    tick(DB + 6);
    model_mode();
    check_model("wrap.done");

    // ---- auto-repeat across the minute wrap ----
    set_cur(10, 58);
    push(1, 8, 0);
    push(1, 8, 0);
    check_model("repeat.enter");
    push(0, 75, 0);
    check_model("repeat.held");
    tick(50);
    check_model("repeat.released");
    push(1, 8, 0);
    check_model("repeat.commit");

    // ---- simultaneous MODE and UP in SET_HOUR ----
    set_cur(5, 30);
    push(1, 8, 0);
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    tick(12);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    tick(DB + 4);
    model_mode();
    check_model("simul");
    push(0, 8, 0);
    check_model("simul.min_up");
    push(1, 8, 0);
    check_model("simul.commit");

    // ---- blink in SET_HOUR, blink restart on UP, blink + timeout in SET_MIN ----
    set_cur(7, 7);
    drive(1, 1'b1);
    tick(EVT_LAT + 1);
    model_mode();
    for (int k = 0; k < 2 * BH; k++) begin
      if (k == 3) drive(1, 1'b0);
      chk("blink.hour", blink_mask, ((k / BH) % 2) ? 4'b1100 : 4'b0000);
      tick(1);
    end
    drive(0, 1'b1);
    tick(EVT_LAT + 1);
    for (int k = 0; k < BH + 2; k++) begin
      if (k == 0) drive(0, 1'b0);
      chk("blink.up_restart", blink_mask, (k < BH) ? 4'b0000 : 4'b1100);
      tick(1);
    end
    model_up(EVT_LAT + 1);
    tick(DB + 4);
    check_model("blink.hour_up");
    drive(1, 1'b1);
    tick(EVT_LAT + 1);
    model_mode();
    for (int k = 0; k < TO; k++) begin
      if (k == 3) drive(1, 1'b0);
      chk("timeout.blink", blink_mask, ((k / BH) % 2) ? 4'b0011 : 4'b0000);
      chk("timeout.frozen", run_en, 0);
      tick(1);
    end
    m_state = 0;
    chk("timeout.blink_off", blink_mask, 0);
    check_model("timeout");

    // ---- randomized edit sessions ----
    for (int it = 0; it < 12; it++) begin
      set_cur($urandom_range(0, 23), $urandom_range(0, 59));
      if ($urandom_range(0, 1) == 1) push(0, $urandom_range(6, 20), 1);
      check_model("rnd.run_up");
      push(1, $urandom_range(6, 20), 1);
      check_model("rnd.enter");
      repeat ($urandom_range(0, 3)) begin
        push(0, $urandom_range(6, 90), 1);
        check_model("rnd.hour");
      end
      push(1, $urandom_range(6, 20), 1);
      check_model("rnd.min_enter");
      repeat ($urandom_range(0, 3)) begin
        push(0, $urandom_range(6, 90), 1);
        check_model("rnd.min");
      end
      if ($urandom_range(0, 2) == 0) begin
        tick(TO + 10);
        m_state = 0;
        check_model("rnd.timeout");
      end else begin
        push(1, $urandom_range(6, 20), 1);
        check_model("rnd.commit");
        chk("rnd.load_val", last_load_v, m_load_v);
        chk("rnd.load_run", last_load_run, 1);
      end
    end

    // ---- reset asserted mid-edit ----
    set_cur(12, 34);
    push(1, 8, 0);
    push(1, 8, 0);
    push(0, 8, 0);
    check_model("mid.pre");
    rst_n = 1'b0;
    #1;
    chk("mid.run_en", run_en, 1);
    chk("mid.load", load, 0);
    chk("mid.blink", blink_mask, 0);
    chk("mid.shadow", sh_h() * 100 + sh_m(), 0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    m_state = 0;
    m_h = 0;
    m_m = 0;
    check_model("mid.after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
